my_ram_fifo_ext: RTL and testbench

Parametrised, Block-RAM-based synchronous FIFO. It generalises the team's RAM FIFO with a selectable first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. It sits between producer and consumer datapaths in a single clock domain and stores data in the existing dual-port RAM macro `my_ram` (synchronous read, 1-cycle latency).

---
 rtl/my_ram_fifo_ext.sv | 202 ++++++++++++++++++++
 tb/tb_my_ram_fifo_ext.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_ram_fifo_ext.sv
// Block-RAM backed synchronous FIFO with optional first-word-fall-through, programmable
// almost-full/almost-empty thresholds, occupancy count, synchronous flush and sticky error flags.

module my_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read data is registered and holds its value until the next read enable.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

module my_ram_fifo_ext #(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int FWFT      = 0,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_flush,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_afull,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_empty,
  output logic              o_aempty,
  output logic [CW-1:0]     o_count,
  output logic              o_ovf,
  output logic              o_udf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [AW-1:0]     wrptr_q, wrptr_d, rdptr_q, rdptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc, empty, ram_rd_en;
  logic [DATA_W-1:0] ram_rdata;

  assign o_full   = (count_q == DEPTH_C);
  assign o_afull  = (count_q >= AF_C);
  assign o_aempty = (count_q <= AE_C);
  assign o_count  = count_q;
  assign o_empty  = empty;
  assign o_ovf    = ovf_q;
  assign o_udf    = udf_q;

  // Request/accept: a write is taken on any edge where i_wren is high, o_full is low and
  // no flush is requested; a pop likewise needs i_rden, !o_empty and no flush. Requests
  // that are not taken leave all state untouched except the matching sticky error flag.
  assign wr_acc = i_wren & ~o_full & ~i_flush;
  assign rd_acc = i_rden & ~empty & ~i_flush;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (i_flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc)    wrptr_d = (wrptr_q == LAST_C) ? '0 : wrptr_q + 1'b1;
      if (ram_rd_en) rdptr_d = (rdptr_q == LAST_C) ? '0 : rdptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (i_wren & o_full) ovf_d = 1'b1;
      if (i_rden & empty)  udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  my_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wrptr_q),
    .wr_data_i (i_wrdata),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (rdptr_q),
    .rd_data_o (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
    logic              pend_q, pend_d, outv_q, outv_d;
    logic [DATA_W-1:0] outd_q, outd_d;
    logic              slot_free, rd_issue;

    // pend_q marks a word sitting in the RAM read register on its way to the output
    // register; a new RAM read is issued only when that slot is free or draining.
    assign slot_free = ~outv_q | rd_acc;
    assign rd_issue  = (ram_cnt_q != '0) & (~pend_q | slot_free) & ~i_flush;

    always_comb begin
      ram_cnt_d = ram_cnt_q;
      pend_d    = pend_q;
      outv_d    = outv_q;
      outd_d    = outd_q;
      if (i_flush) begin
        ram_cnt_d = '0;
        pend_d    = 1'b0;
        outv_d    = 1'b0;
      end else begin
        case ({wr_acc, rd_issue})
          2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
          2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
          default: ram_cnt_d = ram_cnt_q;
        endcase
        if (pend_q & slot_free) begin
          outv_d = 1'b1;
          outd_d = ram_rdata;
        end else if (rd_acc) begin
          outv_d = 1'b0;
        end
        if (rd_issue)       pend_d = 1'b1;
        else if (slot_free) pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        ram_cnt_q <= '0;
        pend_q    <= 1'b0;
        outv_q    <= 1'b0;
        outd_q    <= '0;
      end else begin
        ram_cnt_q <= ram_cnt_d;
        pend_q    <= pend_d;
        outv_q    <= outv_d;
        outd_q    <= outd_d;
      end
    end

    assign ram_rd_en = rd_issue;
    assign empty     = ~outv_q;
    assign o_rdvalid = outv_q;
    assign o_rddata  = outd_q;
  end else begin : g_std
    logic rdv_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rdv_q <= 1'b0;
      else       rdv_q <= rd_acc;
    end

    assign ram_rd_en = rd_acc;
    assign empty     = (count_q == '0);
    assign o_rdvalid = rdv_q;
    assign o_rddata  = ram_rdata;
  end
endmodule

// File: tb/tb_my_ram_fifo_ext.sv
// Randomised and directed stimulus on three FIFO configurations sharing one input set,
// each checked against a queue-based reference model with timestamped FWFT visibility.

module tb_my_ram_fifo_ext;
  typedef struct {
    logic [7:0] data;
    int         twr;
  } ent_t;

  localparam int    D_P  [3] = '{16, 5, 16};
  localparam int    FW_P [3] = '{0, 0, 1};
  localparam int    AF_P [3] = '{14, 3, 14};
  localparam int    AE_P [3] = '{2, 2, 2};
  localparam string NM   [3] = '{"std16", "std5", "fwft16"};

  logic       clk;
  logic       rstn;
  logic       i_flush;
  logic       i_wren;
  logic       i_rden;
  logic [7:0] i_wrdata;

  logic [2:0] full_w, afull_w, rdv_w, empty_w, aempty_w, ovf_w, udf_w;
  logic [7:0] rd0, rd1, rd2;
  logic [4:0] cnt0, cnt2;
  logic [2:0] cnt1;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  ent_t q0[$], q1[$], q2[$];
  int m_ovf[3], m_udf[3], m_rdv[3], m_rdat[3], m_lvis[3], m_lpop[3], m_hvis[3];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  my_ram_fifo_ext #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_wren(i_wren), .i_wrdata(i_wrdata),
    .o_full(full_w[0]), .o_afull(afull_w[0]), .i_rden(i_rden), .o_rddata(rd0),
    .o_rdvalid(rdv_w[0]), .o_empty(empty_w[0]), .o_aempty(aempty_w[0]), .o_count(cnt0),
    .o_ovf(ovf_w[0]), .o_udf(udf_w[0]));

  my_ram_fifo_ext #(.DATA_W(8), .DEPTH(5), .FWFT(0)) u_d5 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_wren(i_wren), .i_wrdata(i_wrdata),
    .o_full(full_w[1]), .o_afull(afull_w[1]), .i_rden(i_rden), .o_rddata(rd1),
    .o_rdvalid(rdv_w[1]), .o_empty(empty_w[1]), .o_aempty(aempty_w[1]), .o_count(cnt1),
    .o_ovf(ovf_w[1]), .o_udf(udf_w[1]));

  my_ram_fifo_ext #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fw (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_wren(i_wren), .i_wrdata(i_wrdata),
    .o_full(full_w[2]), .o_afull(afull_w[2]), .i_rden(i_rden), .o_rddata(rd2),
    .o_rdvalid(rdv_w[2]), .o_empty(empty_w[2]), .o_aempty(aempty_w[2]), .o_count(cnt2),
    .o_ovf(ovf_w[2]), .o_udf(udf_w[2]));

  // ---------------- reference model ----------------
  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t q_head(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_push(input int i, input ent_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int i, output ent_t e);
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Edge after which a FWFT head word shows at the output: one edge to read it out of
  // the RAM (not before the previous word has left the read stage), one more to load
  // the output register (not before the previous word has been popped).
  function automatic int vis_of(input int i, input int twr);
    int t_rd;
    t_rd = imax(twr + 1, m_lvis[i]);
    return imax(t_rd + 1, m_lpop[i]);
  endfunction

  function automatic int exp_empty(input int i, input int t);
    if (FW_P[i] == 0) return (q_size(i) == 0) ? 1 : 0;
    return (q_size(i) > 0 && m_hvis[i] <= t) ? 0 : 1;
  endfunction

  task automatic model_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
    m_ovf[i]  = 0;
    m_udf[i]  = 0;
    m_rdv[i]  = 0;
    m_rdat[i] = 0;
    m_lvis[i] = -1000;
    m_lpop[i] = -1000;
    m_hvis[i] = 0;
  endtask

  task automatic model_edge(input int i, input int fullp, input int emptyp, input int e);
    ent_t x;
    int   wa, ra;
    if (!rstn || i_flush) begin
      model_clear(i);
      return;
    end
    wa = (i_wren && fullp == 0) ? 1 : 0;
    ra = (i_rden && emptyp == 0) ? 1 : 0;
    if (i_wren && fullp != 0) m_ovf[i] = 1;
    if (i_rden && emptyp != 0) m_udf[i] = 1;
    m_rdv[i] = ra;
    if (ra != 0) begin
      q_pop(i, x);
      m_rdat[i] = int'(x.data);
      m_lpop[i] = e;
      m_lvis[i] = m_hvis[i];
      if (q_size(i) > 0) m_hvis[i] = vis_of(i, q_head(i).twr);
    end
    if (wa != 0) begin
      x.data = i_wrdata;
      x.twr  = e;
      q_push(i, x);
      if (q_size(i) == 1) m_hvis[i] = vis_of(i, e);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  function automatic logic [31:0] obs_cnt(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  function automatic logic [31:0] obs_rd(input int i);
    case (i)
      0:       return 32'(rd0);
      1:       return 32'(rd1);
      default: return 32'(rd2);
    endcase
  endfunction

  task automatic compare(input int i);
    int c, em;
    c  = q_size(i);
    em = exp_empty(i, edge_n);
    check({NM[i], ".count"},  obs_cnt(i),  c);
    check({NM[i], ".full"},   full_w[i],   (c == D_P[i]));
    check({NM[i], ".afull"},  afull_w[i],  (c >= AF_P[i]));
    check({NM[i], ".aempty"}, aempty_w[i], (c <= AE_P[i]));
    check({NM[i], ".empty"},  empty_w[i],  em);
    check({NM[i], ".ovf"},    ovf_w[i],    m_ovf[i]);
    check({NM[i], ".udf"},    udf_w[i],    m_udf[i]);
    if (FW_P[i] != 0) begin
      check({NM[i], ".rdvalid"}, rdv_w[i], (em == 0));
      if (em == 0) check({NM[i], ".rddata"}, obs_rd(i), q_head(i).data);
    end else begin
      check({NM[i], ".rdvalid"}, rdv_w[i], m_rdv[i]);
      if (m_rdv[i] != 0) check({NM[i], ".rddata"}, obs_rd(i), m_rdat[i]);
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < 3; i++) compare(i);
    check("fwft16.rddata_rst", obs_rd(2), 0);
  endtask

  // ---------------- driver ----------------
  task automatic at_edge();
    int fp[3];
    int ep[3];
    for (int i = 0; i < 3; i++) begin
      fp[i] = (q_size(i) == D_P[i]) ? 1 : 0;
      ep[i] = exp_empty(i, edge_n);
    end
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 3; i++) model_edge(i, fp[i], ep[i], edge_n);
    #1;
    for (int i = 0; i < 3; i++) compare(i);
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
    @(negedge clk);
    i_wren   = w;
    i_wrdata = d;
    i_rden   = r;
    i_flush  = f;
    at_edge();
  endtask

  task automatic async_reset();
    @(negedge clk);
    i_wren   = 1'b1;
    i_wrdata = 8'h99;
    i_rden   = 1'b1;
    i_flush  = 1'b0;
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_clear(i);
    check_reset();
    @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rstn    = 1'b1;
    i_wren  = 1'b0;
    i_rden  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] dat;
    rstn     = 1'b0;
    i_flush  = 1'b0;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;
    for (int i = 0; i < 3; i++) model_clear(i);
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rstn = 1'b1;

    // fill with 0..15, one rejected write, drain plus one rejected read
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous read/write when full, then when empty
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, 8'(16 + k), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // depth-5 wrap rounds with continuous data
    step(1'b0, 8'h00, 1'b0, 1'b1);
    dat = 8'h40;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        step(1'b1, dat, 1'b0, 1'b0);
        dat = dat + 8'd1;
      end
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // FWFT single word latency, then streaming
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hC0 + k), 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // flush at half full with a concurrent write
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // randomised traffic with rare flushes and one asynchronous reset mid-burst
    for (int c = 0; c < 900; c++) begin
      int wp;
      int rp;
      wp = (c < 450) ? 70 : 35;
      rp = (c < 450) ? 40 : 70;
      step(($urandom_range(0, 99) < wp), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < rp), ($urandom_range(0, 79) == 0));
      if (c == 600) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
